ahbl_sram_bridge_v2: RTL and testbench
======================================

// Module: ahbl_sram_bridge_v2
// PURPOSE
//  Parametrised AHB-Lite slave to single-port synchronous SRAM bridge; next-gen LSRAM/USRAM front end.
//  Adds configurable data width, per-byte write enables, configurable read latency and ERROR responses.
//  Adds back-pressure from a shared-memory arbiter. Sits between the AHB-Lite matrix slave port and the RAM macro.
// PARAMETERS
//  DWIDTH      32  AHB/SRAM data width; 32 or 64
//  MEM_AWIDTH  16  byte-address width decoded (memory size = MEM_BYTES)
//  MEM_BYTES   65536 implemented bytes; HADDR[MEM_AWIDTH-1:0] >= MEM_BYTES -> ERROR
//  RD_LATENCY  1   SRAM clocks from mem_ce (read) to valid mem_rdata; 1..3
// PORTS
//  HCLK       in   1              AHB clock
//  aresetn    in   1              async active-low reset
//  HSEL       in   1              slave select
//  HREADYIN   in   1              bus ready
//  HTRANS     in   2              IDLE/BUSY/NONSEQ/SEQ
//  HWRITE     in   1              1 = write
//  HSIZE      in   3              transfer size
//  HADDR      in   32             byte address
//  HWDATA     in   DWIDTH         write data (data phase)
//  HREADYOUT  out  1              slave ready
//  HRESP      out  1              0 OKAY, 1 ERROR
//  HRDATA     out  DWIDTH         read data
//  mem_busy   in   1              arbiter holds SRAM; no access may issue
//  mem_ce     out  1              SRAM access strobe (one cycle per beat)
//  mem_we     out  1              write when mem_ce
//  mem_be     out  DWIDTH/8       byte write enables
//  mem_addr   out  MEM_AWIDTH-log2(DWIDTH/8)  word address
//  mem_wdata  out  DWIDTH         lane-aligned write data
//  mem_rdata  in   DWIDTH         SRAM read data
// BEHAVIOUR
//  Reset: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, mem_ce=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
//  Address phase accepted when HSEL&HREADYIN&HREADYOUT&HTRANS[1]; HADDR/HSIZE/HWRITE registered.
//  IDLE/BUSY transfers, or HSEL=0: no access, zero-wait OKAY.
//  Error check at accept: HSIZE>log2(DWIDTH/8), misaligned HADDR, or addr>=MEM_BYTES.
//  States: IDLE, WR, RD, ERR1, ERR2.
//  WR (data phase): drive mem_ce=mem_we=1, mem_be/mem_wdata from HWDATA; HREADYOUT=1 same cycle.
//  WR -> IDLE, or WR/RD/ERR1 on back-to-back accept.
//  RD: mem_ce=1 first data-phase cycle; HREADYOUT=0 for RD_LATENCY cycles.
//  RD: then HREADYOUT=1, HRDATA=mem_rdata (registered, held until next read completes).
//  ERR1: HREADYOUT=0, HRESP=1; ERR2: HREADYOUT=1, HRESP=1; no mem_ce. ERR2 -> IDLE (accepts new cmd).
//  mem_busy=1 in WR/RD first cycle: mem_ce withheld, HREADYOUT=0, state held.
//  mem_busy: retries each cycle; HWDATA stable by AHB rule. Read latency counts from actual issue.
//  Byte lanes: mem_be = ((1<<2^HSIZE)-1) << HADDR[log2(DWIDTH/8)-1:0].
//  Byte lanes: mem_wdata = HWDATA (AHB already lane-aligned); reads return full word.
//  Bursts: SEQ treated as NONSEQ; HBURST ignored. INCR/WRAP of any length supported.
//  Bursts: writes 1 beat/cycle, reads 1+RD_LATENCY cycles/beat.
//  Write then read of same address back-to-back: write issues first cycle, read next; no forwarding needed.
//  Reset mid-transfer: state to IDLE immediately, outputs to reset values, in-flight read discarded.
// STRUCTURE
//  Package ahbl_pkg: HTRANS_*, HRESP_OKAY/ERROR, HSIZE_* constants, state enum.
//  Package ahbl_pkg: function be_gen(size, addr_lsb, DWIDTH).
//  Sub-module ahbl_sram_lane_dec: comb HSIZE/addr -> mem_be + size/alignment error flag.
//  Top: address-phase regs, FSM, read-latency counter (2 bits), HRDATA register.
// TESTING
//  DWIDTH=32: byte write 0xA5 @0x3 -> mem_be=4'b1000, mem_wdata[31:24]=A5, HREADYOUT=1, HRESP=0.
//  RD_LATENCY=2, read @0x10 -> mem_addr=0x4, 2 cycles HREADYOUT=0, then HRDATA=mem_rdata.
//  DWIDTH=64: INCR4 word writes @0x100 -> mem_be 0x0F,0xF0,0x0F,0xF0, one per cycle, no waits.
//  Read @MEM_BYTES -> HRESP=1 two cycles (HREADYOUT 0 then 1), mem_ce never asserted.
//  Halfword @0x1 -> ERROR, mem_ce never asserted.
//  mem_busy high 3 cycles during write -> HREADYOUT=0 x3, single mem_ce after release, data intact.
//  aresetn low during RD wait -> HREADYOUT=1, mem_ce=0 next edge; following read returns correct data.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite constants, bridge state encoding and byte-lane helper
// for the SRAM bridge family.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Contiguous run of 2^size lanes starting at addr_lsb, clipped to the bus.
    function automatic logic [7:0] be_gen(
        input logic [2:0] size,
        input logic [2:0] addr_lsb,
        input int         dwidth
    );
        logic [7:0] m;
        logic [7:0] be;
        if (size > HSIZE_DWORD)
            m = 8'hFF;
        else
            m = 8'hFF >> (4'd8 - (4'd1 << size[1:0]));
        m  = m << addr_lsb;
        be = '0;
        for (int i = 0; i < 8; i++)
            if (i < dwidth / 8)
                be[i] = m[i];
        return be;
    endfunction

endpackage

// File: rtl/ahbl_sram_lane_dec.sv
// Address-phase byte-lane decoder: HSIZE/address LSBs to byte enables,
// flagging sizes wider than the bus and misaligned addresses.
module ahbl_sram_lane_dec
    import ahbl_pkg::*;
#(
    parameter  int DWIDTH = 32,
    localparam int NB     = DWIDTH / 8,
    localparam int BW     = $clog2(NB)
) (
    input  logic [2:0]    size,
    input  logic [BW-1:0] addr_lsb,
    output logic [NB-1:0] be,
    output logic          err
);

    logic [2:0] lsb3;
    logic [2:0] amask;

    always_comb begin
        lsb3  = 3'(addr_lsb);
        amask = (3'd1 << size) - 3'd1;
        be    = NB'(be_gen(size, lsb3, DWIDTH));
        err   = (size > 3'(BW)) || ((lsb3 & amask) != 3'd0);
    end

endmodule

// File: rtl/ahbl_sram_bridge_v2.sv
// AHB-Lite slave to single-port synchronous SRAM bridge with byte enables,
// configurable read latency, ERROR responses and arbiter back-pressure.
module ahbl_sram_bridge_v2
    import ahbl_pkg::*;
#(
    parameter  int DWIDTH     = 32,
    parameter  int MEM_AWIDTH = 16,
    parameter  int MEM_BYTES  = 65536,
    parameter  int RD_LATENCY = 1,
    localparam int NB         = DWIDTH / 8,
    localparam int BW         = $clog2(NB),
    localparam int WAW        = MEM_AWIDTH - BW
) (
    input  logic              HCLK,
    input  logic              aresetn,
    input  logic              HSEL,
    input  logic              HREADYIN,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HADDR,
    input  logic [DWIDTH-1:0] HWDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DWIDTH-1:0] HRDATA,
    input  logic              mem_busy,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [NB-1:0]     mem_be,
    output logic [WAW-1:0]    mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam logic [MEM_AWIDTH:0] LIMIT =
        (MEM_AWIDTH + 1)'(MEM_BYTES);

    state_t              state_q;
    state_t              state_d;
    state_t              cmd_st;
    logic [WAW-1:0]      addr_q;
    logic [NB-1:0]       be_q;
    logic [NB-1:0]       dec_be;
    logic                dec_err;
    logic                range_err;
    logic                accept;
    logic                issued_q;
    logic [1:0]          cnt_q;
    logic                rd_done;
    logic [DWIDTH-1:0]   hrdata_q;
    logic                unused_haddr;

    assign unused_haddr = ^HADDR[31:MEM_AWIDTH];

    ahbl_sram_lane_dec #(
        .DWIDTH (DWIDTH)
    ) u_lane_dec (
        .size     (HSIZE),
        .addr_lsb (HADDR[BW-1:0]),
        .be       (dec_be),
        .err      (dec_err)
    );

    always_comb begin
        range_err = {1'b0, HADDR[MEM_AWIDTH-1:0]} >= LIMIT;
        accept    = HSEL && HREADYIN && HREADYOUT &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
        if (dec_err || range_err)
            cmd_st = ST_ERR1;
        else if (HWRITE)
            cmd_st = ST_WR;
        else
            cmd_st = ST_RD;
    end

    assign rd_done  = (state_q == ST_RD) && issued_q && (cnt_q == 2'd0);
    assign mem_addr = addr_q;

    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // A beat retires whenever HREADYOUT is high; ERR1 always steps to ERR2.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_ERR1)
            state_d = ST_ERR2;
        else if (HREADYOUT)
            state_d = accept ? cmd_st : ST_IDLE;
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = hrdata_q;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        unique case (state_q)
            ST_WR: begin
                if (mem_busy) begin
                    HREADYOUT = 1'b0;
                end else begin
                    mem_ce    = 1'b1;
                    mem_we    = 1'b1;
                    mem_be    = be_q;
                    mem_wdata = HWDATA;
                end
            end
            ST_RD: begin
                if (!issued_q) begin
                    HREADYOUT = 1'b0;
                    mem_ce    = !mem_busy;
                end else if (cnt_q != 2'd0) begin
                    HREADYOUT = 1'b0;
                end else begin
                    HRDATA = mem_rdata;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: begin
                HRESP = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    // Latency counts from the cycle the read actually reaches the SRAM.
    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            addr_q   <= '0;
            be_q     <= '0;
            issued_q <= 1'b0;
            cnt_q    <= 2'd0;
            hrdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= HADDR[MEM_AWIDTH-1:BW];
                be_q   <= dec_be;
            end
            if (state_q == ST_RD && !issued_q && !mem_busy) begin
                issued_q <= 1'b1;
                cnt_q    <= 2'(RD_LATENCY - 1);
            end else if (state_q == ST_RD && issued_q && cnt_q != 2'd0) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (rd_done) begin
                issued_q <= 1'b0;
                hrdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_sram_bridge_v2.sv
// Bench for ahbl_sram_bridge_v2: vector table, directed multi-cycle
// sequences and random traffic against a byte-array memory model.
module tb_ahbl_sram_bridge_v2;

    localparam int DW     = 32;
    localparam int AW     = 16;
    localparam int MBYTES = 32'hC000;
    localparam int RDLAT  = 2;

    logic        HCLK = 1'b0;
    logic        aresetn;
    logic        HSEL;
    logic        HREADYIN;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        mem_busy;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    ahbl_sram_bridge_v2 #(
        .DWIDTH     (DW),
        .MEM_AWIDTH (AW),
        .MEM_BYTES  (MBYTES),
        .RD_LATENCY (RDLAT)
    ) dut (
        .HCLK      (HCLK),
        .aresetn   (aresetn),
        .HSEL      (HSEL),
        .HREADYIN  (HREADYIN),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .mem_busy  (mem_busy),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 HCLK = ~HCLK;
    assign HREADYIN = HREADYOUT;

    // SRAM macro model with RDLAT-cycle read pipeline
    logic [31:0] sram [0:16383];
    logic [31:0] p0, p1;
    bit          sram_init;
    always @(posedge HCLK) begin
        if (!sram_init) begin
            for (int i = 0; i < 16384; i++) sram[i] <= '0;
            sram_init <= 1'b1;
        end else if (mem_ce && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        p0 <= (mem_ce && !mem_we) ? sram[mem_addr] : 32'hDEAD_BEEF;
        p1 <= p0;
    end
    assign mem_rdata = p1;

    bit rnd_busy, busy_rnd, busy_force;
    always @(posedge HCLK) busy_rnd <= ($urandom_range(0, 3) == 0);
    assign mem_busy = rnd_busy ? busy_rnd : busy_force;

    int          ce_cnt;
    logic [13:0] last_addr;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;
    always @(posedge HCLK) begin
        if (mem_ce) begin
            ce_cnt     <= ce_cnt + 1;
            last_addr  <= mem_addr;
            last_be    <= mem_be;
            last_wdata <= mem_wdata;
        end
    end

    // Reference memory: plain byte array
    bit [7:0] ref_mem [0:MBYTES-1];

    function automatic bit [31:0] ref_rd(bit [31:0] a);
        bit [31:0] w = a & ~32'd3;
        return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
    endfunction

    task automatic ref_wr(bit [31:0] a, bit [2:0] sz, bit [31:0] wd);
        for (int i = 0; i < (1 << sz); i++)
            ref_mem[a+i] = wd[8*((a % 4) + i) +: 8];
    endtask

    function automatic bit [3:0] be_rule(bit [31:0] a, bit [2:0] sz);
        bit [3:0] be = '0;
        for (int i = 0; i < (1 << sz); i++) be[(a % 4) + i] = 1'b1;
        return be;
    endfunction

    function automatic bit err_rule(bit [31:0] a, bit [2:0] sz);
        return (sz > 3'd2) || ((a % (1 << sz)) != 0) || (a >= MBYTES);
    endfunction

    int n_cmp, n_bad;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd0; HADDR = '0;
    endtask

    task automatic cyc();
        @(posedge HCLK); #1;
    endtask

    task automatic xfer(input bit wr, input bit [2:0] sz,
                        input bit [31:0] a, input bit [31:0] wd,
                        output bit [31:0] rd, output bit r_or,
                        output bit r_and, output int waits,
                        output int nce);
        int c0 = ce_cnt;
        bit done = 1'b0;
        waits = 0; r_or = 1'b0; r_and = 1'b1; rd = '0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; HADDR = a;
        cyc();
        idle_bus();
        HWDATA = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge HCLK);
            r_or  |= HRESP;
            r_and &= HRESP;
            if (HREADYOUT) begin
                done = 1'b1;
                rd   = HRDATA;
            end else begin
                waits++;
            end
            cyc();
        end
        if (!done) chk("xfer-timeout", 0, 1);
        nce = ce_cnt - c0;
    endtask

    task automatic run_one(string tag, bit wr, bit [2:0] sz,
                           bit [31:0] a, bit [31:0] wd, bit err,
                           int ewaits, bit [3:0] ebe);
        bit [31:0] rd;
        bit        ro, ra;
        int        w, nce;
        xfer(wr, sz, a, wd, rd, ro, ra, w, nce);
        chk({tag, "-resp"}, {ro, ra}, err ? 2'b11 : 2'b00);
        chk({tag, "-ce"}, nce, err ? 0 : 1);
        if (ewaits >= 0)
            chk({tag, "-waits"}, w, ewaits);
        else if (err || wr)
            chk({tag, "-waits"}, w >= (err ? 1 : 0), 1);
        else
            chk({tag, "-waits"}, w >= RDLAT, 1);
        if (!err) chk({tag, "-addr"}, last_addr, a[15:2]);
        if (!err && wr) begin
            chk({tag, "-be"}, last_be, ebe);
            chk({tag, "-wdata"}, last_wdata, wd);
            ref_wr(a, sz, wd);
        end
        if (!err && !wr) chk({tag, "-rdata"}, rd, ref_rd(a));
    endtask

    typedef struct {
        bit        wr;
        bit [2:0]  sz;
        bit [31:0] addr;
        bit [31:0] wd;
        bit        err;
        int        waits;
        bit [3:0]  be;
    } vec_t;

    vec_t vt [13];

    initial begin
        bit [31:0] bd [4];
        bit [31:0] x, a, wd;
        bit [2:0]  sz;
        bit        wr, done;
        int        c0, w;

        vt[0]  = '{1, 0, 32'h0003, 32'hA500_0000, 0, 0, 4'b1000};
        vt[1]  = '{1, 2, 32'h0010, 32'h1234_5678, 0, 0, 4'b1111};
        vt[2]  = '{0, 2, 32'h0010, 32'h0,         0, 2, 4'b0000};
        vt[3]  = '{1, 1, 32'h0002, 32'hBEEF_0000, 0, 0, 4'b1100};
        vt[4]  = '{0, 2, 32'h0000, 32'h0,         0, 2, 4'b0000};
        vt[5]  = '{0, 1, 32'h0001, 32'h0,         1, 1, 4'b0000};
        vt[6]  = '{0, 2, 32'hC000, 32'h0,         1, 1, 4'b0000};
        vt[7]  = '{1, 2, 32'h0002, 32'hFFFF_FFFF, 1, 1, 4'b0000};
        vt[8]  = '{1, 3, 32'h0000, 32'h0000_0001, 1, 1, 4'b0000};
        vt[9]  = '{1, 0, 32'hBFFF, 32'h5A00_0000, 0, 0, 4'b1000};
        vt[10] = '{0, 0, 32'hBFFF, 32'h0,         0, 2, 4'b0000};
        vt[11] = '{0, 2, 32'hBFFC, 32'h0,         0, 2, 4'b0000};
        vt[12] = '{1, 0, 32'h0011, 32'h0000_CC00, 0, 0, 4'b0010};

        idle_bus();
        HWDATA = '0; busy_force = 1'b0; rnd_busy = 1'b0;
        aresetn = 1'b0;
        repeat (3) cyc();

        @(negedge HCLK);
        chk("rst-hready", HREADYOUT, 1);
        chk("rst-hresp",  HRESP, 0);
        chk("rst-hrdata", HRDATA, 0);
        chk("rst-mem", {mem_ce, mem_we, mem_be, mem_addr, mem_wdata}, 0);
        cyc();
        aresetn = 1'b1;
        cyc();

        // BUSY transfer: not accepted, zero-wait OKAY
        c0 = ce_cnt;
        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h40;
        cyc();
        idle_bus();
        @(negedge HCLK);
        chk("busy-hready", HREADYOUT, 1);
        chk("busy-hresp", HRESP, 0);
        cyc();
        chk("busy-ce", ce_cnt - c0, 0);

        for (int i = 0; i < 13; i++)
            run_one($sformatf("vec%0d", i), vt[i].wr, vt[i].sz,
                    vt[i].addr, vt[i].wd, vt[i].err, vt[i].waits, vt[i].be);

        // INCR4 word write burst: one SRAM write per cycle, no waits
        for (int i = 0; i < 4; i++) bd[i] = 32'hC0DE_0000 + i;
        for (int beat = 0; beat <= 4; beat++) begin
            if (beat < 4) begin
                HSEL = 1'b1; HTRANS = (beat == 0) ? 2'b10 : 2'b11;
                HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h100 + 4 * beat;
            end else begin
                idle_bus();
            end
            if (beat > 0) begin
                HWDATA = bd[beat-1];
                @(negedge HCLK);
                chk("burst-hready", HREADYOUT, 1);
                chk("burst-ce", {mem_ce, mem_we}, 2'b11);
                chk("burst-addr", mem_addr, 14'h40 + 14'(beat - 1));
                chk("burst-wdata", mem_wdata, bd[beat-1]);
            end
            cyc();
        end
        for (int i = 0; i < 4; i++) ref_wr(32'h100 + 4 * i, 3'd2, bd[i]);
        run_one("burst-rb", 0, 2, 32'h108, 0, 0, RDLAT, 0);

        // Arbiter holds SRAM for three data-phase cycles of a write
        c0 = ce_cnt;
        x  = 32'h8BAD_F00D;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
        HADDR = 32'h204; busy_force = 1'b1;
        cyc();
        idle_bus();
        HWDATA = x;
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            chk("hold-hready", HREADYOUT, 0);
            chk("hold-ce", mem_ce, 0);
            cyc();
        end
        busy_force = 1'b0;
        @(negedge HCLK);
        chk("hold-rel-hready", HREADYOUT, 1);
        chk("hold-rel-ce", {mem_ce, mem_we}, 2'b11);
        chk("hold-rel-wdata", mem_wdata, x);
        cyc();
        chk("hold-ce-count", ce_cnt - c0, 1);
        ref_wr(32'h204, 3'd2, x);
        run_one("hold-rb", 0, 2, 32'h204, 0, 0, RDLAT, 0);

        // Write immediately followed by read of the same word
        x = 32'h5EED_1234;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
        HADDR = 32'h300;
        cyc();
        HTRANS = 2'b10; HWRITE = 1'b0; HWDATA = x;
        @(negedge HCLK);
        chk("wr2rd-wr", {HREADYOUT, mem_ce, mem_we}, 3'b111);
        cyc();
        idle_bus();
        ref_wr(32'h300, 3'd2, x);
        done = 1'b0; w = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin
                done = 1'b1;
                chk("wr2rd-rdata", HRDATA, ref_rd(32'h300));
            end else begin
                w++;
            end
            cyc();
        end
        chk("wr2rd-done", done, 1);
        chk("wr2rd-waits", w, RDLAT);

        // Reset while a read is waiting on the SRAM
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
        HADDR = 32'h10;
        cyc();
        idle_bus();
        @(negedge HCLK);
        chk("rstrd-wait", {HREADYOUT, mem_ce}, 2'b01);
        cyc();
        #2 aresetn = 1'b0;
        #1;
        chk("rstrd-hready", HREADYOUT, 1);
        chk("rstrd-ce", mem_ce, 0);
        chk("rstrd-hrdata", HRDATA, 0);
        cyc();
        aresetn = 1'b1;
        @(negedge HCLK);
        chk("rstrd-post", {HREADYOUT, HRESP, mem_ce}, 3'b100);
        cyc();
        run_one("rstrd-rb", 0, 2, 32'h10, 0, 0, RDLAT, 0);

        // Random traffic with random arbiter back-pressure
        rnd_busy = 1'b1;
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a  = (($urandom_range(0, 3) == 0) ? 32'hBFC0 : 32'h0) +
                 32'($urandom_range(0, 127));
            if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << sz) - 1);
            wd = $urandom;
            run_one($sformatf("rnd%0d", n), wr, sz, a, wd,
                    err_rule(a, sz), -1,
                    err_rule(a, sz) ? 4'b0 : be_rule(a, sz));
        end
        rnd_busy = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
